// File: rtl/fl_alloc_arb_if.sv
// Bundle between the free-list arbiter, its requesters and the free list.
// master drives requests and free-list status; slave is the arbiter.
interface fl_alloc_arb_if #(
  parameter int NR    = 4,
  parameter int EN    = 64,
  parameter int QUOTA = EN,
  parameter int CW    = $clog2(QUOTA + 1)
);
  logic              flush;
  logic [NR-1:0]     areq_vld;
  logic [NR-1:0]     areq_rdy;
  logic [EN-1:0]     a_entry;
  logic [NR-1:0]     rreq_vld;
  logic [NR-1:0]     rreq_rdy;
  logic [NR*EN-1:0]  rreq_entry;
  logic              fl_vld;
  logic              fl_rdy;
  logic [EN-1:0]     fl;
  logic              fl_ret_vld;
  logic              fl_ret_rdy;
  logic [EN-1:0]     fl_ret;
  logic              fl_flush;
  logic [NR*CW-1:0]  used;
  logic              err_unf;

  modport master (
    output flush, areq_vld, rreq_vld, rreq_entry, fl_vld, fl, fl_ret_rdy,
    input  areq_rdy, a_entry, rreq_rdy, fl_rdy, fl_ret_vld, fl_ret,
           fl_flush, used, err_unf
  );

  modport slave (
    input  flush, areq_vld, rreq_vld, rreq_entry, fl_vld, fl, fl_ret_rdy,
    output areq_rdy, a_entry, rreq_rdy, fl_rdy, fl_ret_vld, fl_ret,
           fl_flush, used, err_unf
  );
endinterface

// File: rtl/fl_alloc_arb.sv
// Round-robin alloc/return arbiter sharing one free list among NR requesters with per-requester quota.
// Alloc grant is combinational (0 cycles); returns pass through a one-deep register (1 cycle).
// Returns stall (all rreq_rdy low) only while the buffer is full and fl_ret_rdy is low.
module fl_alloc_arb #(
  parameter int NR    = 4,
  parameter int EN    = 64,
  parameter int QUOTA = EN
) (
  input logic           clk,
  input logic           rst_n,
  fl_alloc_arb_if.slave bus
);

  localparam int CW = $clog2(QUOTA + 1);
  localparam int PW = $clog2(NR);
  localparam logic [CW-1:0] QUOTA_C = CW'(QUOTA);

  logic [CW-1:0] used_q [NR];
  logic [PW-1:0] aptr_q;
  logic [PW-1:0] rptr_q;
  logic          rb_vld_q;
  logic [EN-1:0] rb_q;
  logic          err_q;

  logic [NR-1:0] elig;
  logic [NR-1:0] unf;
  logic [NR-1:0] a_gnt;
  logic [NR-1:0] r_acc;
  logic          a_found;
  logic          r_found;
  logic [PW-1:0] a_win;
  logic [PW-1:0] r_win;
  logic          rb_open;
  logic [EN-1:0] r_slice;

  // Returns {found, index} of the first set bit at or after ptr, wrapping at NR.
  function automatic logic [PW:0] rr_pick(input logic [NR-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0]   res;
    logic [PW-1:0] sel;
    int            idx;
    res = '0;
    for (int k = NR - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NR) idx = idx - NR;
      sel = PW'(idx);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] p);
    return (p == PW'(NR - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      elig[i] = bus.areq_vld[i] && (used_q[i] < QUOTA_C);
      unf[i]  = (used_q[i] == '0);
    end
  end

  // Return buffer can take a new entry if empty or draining this cycle.
  assign rb_open = !rb_vld_q || bus.fl_ret_rdy;

  always_comb begin
    {a_found, a_win} = rr_pick(elig, aptr_q);
    {r_found, r_win} = rr_pick(bus.rreq_vld, rptr_q);
    a_gnt = '0;
    r_acc = '0;
    if (a_found && bus.fl_vld) a_gnt[a_win] = 1'b1;
    if (r_found && rb_open)    r_acc[r_win] = 1'b1;
  end

  assign r_slice = bus.rreq_entry[EN*int'(r_win) +: EN];

  assign bus.areq_rdy   = a_gnt;
  assign bus.a_entry    = bus.fl;
  assign bus.fl_rdy     = |a_gnt;
  assign bus.rreq_rdy   = r_acc;
  assign bus.fl_ret_vld = rb_vld_q;
  assign bus.fl_ret     = rb_q;
  assign bus.fl_flush   = bus.flush;
  assign bus.err_unf    = err_q;

  for (genvar g = 0; g < NR; g++) begin : g_used
    assign bus.used[g*CW +: CW] = used_q[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aptr_q   <= '0;
      rptr_q   <= '0;
      rb_vld_q <= 1'b0;
      rb_q     <= '0;
      err_q    <= 1'b0;
    end else if (bus.flush) begin
      aptr_q   <= '0;
      rptr_q   <= '0;
      rb_vld_q <= 1'b0;
      rb_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      if (|a_gnt) aptr_q <= rr_next(a_win);
      if (|r_acc) begin
        rb_q     <= r_slice;
        rb_vld_q <= 1'b1;
        rptr_q   <= rr_next(r_win);
      end else if (bus.fl_ret_rdy) begin
        rb_vld_q <= 1'b0;
      end
      if (|(r_acc & unf)) err_q <= 1'b1;
    end
  end

  // Underflowing returns saturate at zero; a same-cycle alloc+return nets out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) used_q[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NR; i++) used_q[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        case ({a_gnt[i], r_acc[i]})
          2'b10:   used_q[i] <= used_q[i] + CW'(1);
          2'b01:   if (!unf[i]) used_q[i] <= used_q[i] - CW'(1);
          default: used_q[i] <= used_q[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fl_alloc_arb.sv
// Bench for fl_alloc_arb: directed scenarios plus random traffic, all outputs
// compared each cycle against a queue/array reference model of the arbiter rules.
module tb_fl_alloc_arb;
  localparam int NR    = 4;
  localparam int EN    = 16;
  localparam int QUOTA = 2;
  localparam int CW    = $clog2(QUOTA + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fl_alloc_arb_if #(.NR(NR), .EN(EN), .QUOTA(QUOTA)) ifc ();

  fl_alloc_arb #(.NR(NR), .EN(EN), .QUOTA(QUOTA)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  int            m_used [NR];
  int            m_aptr, m_rptr;
  bit            m_rb_vld, m_err;
  logic [EN-1:0] m_rb;
  int            a_win, r_win;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] req, input int ptr);
    int order[$];
    for (int k = 0; k < NR; k++) order.push_back((ptr + k) % NR);
    foreach (order[j]) if (req[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [EN-1:0] onehot();
    logic [EN-1:0] v;
    v = '0;
    v[$urandom_range(EN - 1, 0)] = 1'b1;
    return v;
  endfunction

  function automatic int used_of(input int i);
    return int'(ifc.used[i*CW +: CW]);
  endfunction

  task automatic rand_entries();
    for (int i = 0; i < NR; i++) ifc.rreq_entry[i*EN +: EN] = onehot();
  endtask

  task automatic idle();
    ifc.flush      = 1'b0;
    ifc.areq_vld   = '0;
    ifc.rreq_vld   = '0;
    ifc.fl_vld     = 1'b0;
    ifc.fl         = '0;
    ifc.fl_ret_rdy = 1'b1;
    ifc.rreq_entry = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_used[i] = 0;
    m_aptr = 0; m_rptr = 0; m_rb_vld = 0; m_err = 0; m_rb = '0;
  endtask

  task automatic model_comb();
    logic [NR-1:0] elig;
    for (int i = 0; i < NR; i++) elig[i] = ifc.areq_vld[i] && (m_used[i] < QUOTA);
    a_win = ifc.fl_vld ? pick(elig, m_aptr) : -1;
    r_win = (!m_rb_vld || ifc.fl_ret_rdy) ? pick(ifc.rreq_vld, m_rptr) : -1;
  endtask

  task automatic check_outputs();
    logic [NR-1:0]    ea, er;
    logic [NR*CW-1:0] eu;
    ea = '0; er = '0;
    if (a_win >= 0) ea[a_win] = 1'b1;
    if (r_win >= 0) er[r_win] = 1'b1;
    for (int i = 0; i < NR; i++) eu[i*CW +: CW] = CW'(m_used[i]);
    chk("areq_rdy", 64'(ifc.areq_rdy), 64'(ea));
    chk("fl_rdy", 64'(ifc.fl_rdy), 64'(a_win >= 0));
    if (a_win >= 0) chk("a_entry", 64'(ifc.a_entry), 64'(ifc.fl));
    chk("rreq_rdy", 64'(ifc.rreq_rdy), 64'(er));
    chk("fl_ret_vld", 64'(ifc.fl_ret_vld), 64'(m_rb_vld));
    if (m_rb_vld) chk("fl_ret", 64'(ifc.fl_ret), 64'(m_rb));
    chk("used", 64'(ifc.used), 64'(eu));
    chk("err_unf", 64'(ifc.err_unf), 64'(m_err));
    chk("fl_flush", 64'(ifc.fl_flush), 64'(ifc.flush));
  endtask

  task automatic model_seq();
    int pre [NR];
    int t, inc, dec;
    if (ifc.flush) begin
      for (int i = 0; i < NR; i++) m_used[i] = 0;
      m_aptr = 0; m_rptr = 0; m_rb_vld = 0; m_err = 0;
      return;
    end
    for (int i = 0; i < NR; i++) pre[i] = m_used[i];
    for (int i = 0; i < NR; i++) begin
      inc = (a_win == i) ? 1 : 0;
      dec = (r_win == i) ? 1 : 0;
      t = pre[i] + inc - dec;
      m_used[i] = (t < 0) ? 0 : t;
      if (dec == 1 && pre[i] == 0) m_err = 1;
    end
    if (a_win >= 0) m_aptr = (a_win + 1) % NR;
    if (r_win >= 0) begin
      m_rb     = ifc.rreq_entry[r_win*EN +: EN];
      m_rb_vld = 1;
      m_rptr   = (r_win + 1) % NR;
    end else if (ifc.fl_ret_rdy) begin
      m_rb_vld = 0;
    end
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    #1;
    model_comb();
    check_outputs();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic do_flush();
    idle();
    ifc.flush = 1'b1;
    step();
    ifc.flush = 1'b0;
  endtask

  initial begin
    logic [EN-1:0] e0, e2;
    idle();
    ifc.fl_vld = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_used", 64'(ifc.used), 64'(0));
    chk("rst_ret_vld", 64'(ifc.fl_ret_vld), 64'(0));
    chk("rst_ret", 64'(ifc.fl_ret), 64'(0));
    chk("rst_err", 64'(ifc.err_unf), 64'(0));
    chk("idle_fl_rdy", 64'(ifc.fl_rdy), 64'(0));
    rst_n = 1'b1;
    step();
    step();

    // Round-robin with all requesting: 0,1,2,3,0,1,2,3 then all at quota
    do_flush();
    ifc.areq_vld = 4'hF;
    ifc.fl_vld   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ifc.fl = onehot();
      #1;
      chk("rr_gnt", 64'(ifc.areq_rdy), 64'(1) << (c % NR));
      step();
    end
    chk("rr_used", 64'(ifc.used), 64'({NR{2'd2}}));
    #1;
    chk("rr_quota", 64'(ifc.areq_rdy), 64'(0));
    step();

    // Quota on a single requester, one return frees exactly one grant
    do_flush();
    ifc.areq_vld = 4'b0010;
    ifc.fl_vld   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ifc.fl = onehot();
      #1;
      chk("q_gnt", 64'(ifc.areq_rdy[1]), 64'(c < 2));
      step();
    end
    ifc.rreq_vld = 4'b0010;
    rand_entries();
    #1;
    chk("q_ret_acc", 64'(ifc.rreq_rdy), 64'(4'b0010));
    chk("q_full", 64'(ifc.areq_rdy), 64'(0));
    step();
    ifc.rreq_vld = '0;
    #1;
    chk("q_regrant", 64'(ifc.areq_rdy), 64'(4'b0010));
    step();
    #1;
    chk("q_full2", 64'(ifc.areq_rdy), 64'(0));
    step();

    // Return backpressure holds the buffer, then requester 2 follows
    do_flush();
    ifc.rreq_vld = 4'b0101;
    rand_entries();
    e0 = ifc.rreq_entry[0 +: EN];
    #1;
    chk("bp_first", 64'(ifc.rreq_rdy), 64'(4'b0001));
    step();
    ifc.fl_ret_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_entries();
      #1;
      chk("bp_hold", 64'(ifc.rreq_rdy), 64'(0));
      chk("bp_ret", 64'(ifc.fl_ret), 64'(e0));
      step();
    end
    ifc.fl_ret_rdy = 1'b1;
    e2 = ifc.rreq_entry[2*EN +: EN];
    #1;
    chk("bp_next", 64'(ifc.rreq_rdy), 64'(4'b0100));
    step();
    #1;
    chk("bp_vld", 64'(ifc.fl_ret_vld), 64'(1));
    chk("bp_ret2", 64'(ifc.fl_ret), 64'(e2));
    chk("bp_third", 64'(ifc.rreq_rdy), 64'(4'b0001));
    step();

    // Simultaneous alloc and return on requester 3
    do_flush();
    ifc.areq_vld = 4'b1000;
    ifc.fl_vld   = 1'b1;
    ifc.fl       = onehot();
    step();
    ifc.rreq_vld = 4'b1000;
    rand_entries();
    #1;
    chk("sc_both", 64'({ifc.areq_rdy, ifc.rreq_rdy}), 64'(8'b1000_1000));
    step();
    idle();
    #1;
    chk("sc_used3", 64'(used_of(3)), 64'(1));
    step();

    // Underflow, then flush clears state and pointers
    do_flush();
    ifc.areq_vld = 4'b0100;
    ifc.fl_vld   = 1'b1;
    ifc.fl       = onehot();
    step();
    idle();
    ifc.rreq_vld = 4'b0001;
    rand_entries();
    e0 = ifc.rreq_entry[0 +: EN];
    step();
    idle();
    ifc.fl_ret_rdy = 1'b0;
    #1;
    chk("unf_err", 64'(ifc.err_unf), 64'(1));
    chk("unf_used0", 64'(used_of(0)), 64'(0));
    chk("unf_fwd_vld", 64'(ifc.fl_ret_vld), 64'(1));
    chk("unf_fwd", 64'(ifc.fl_ret), 64'(e0));
    ifc.flush = 1'b1;
    step();
    ifc.flush = 1'b0;
    #1;
    chk("fl_err", 64'(ifc.err_unf), 64'(0));
    chk("fl_used", 64'(ifc.used), 64'(0));
    chk("fl_rb", 64'(ifc.fl_ret_vld), 64'(0));
    ifc.areq_vld   = 4'hF;
    ifc.fl_vld     = 1'b1;
    ifc.fl         = onehot();
    ifc.rreq_vld   = 4'hF;
    ifc.fl_ret_rdy = 1'b1;
    rand_entries();
    #1;
    chk("fl_aptr", 64'(ifc.areq_rdy), 64'(4'b0001));
    chk("fl_rptr", 64'(ifc.rreq_rdy), 64'(4'b0001));
    step();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      ifc.areq_vld   = NR'($urandom);
      ifc.rreq_vld   = NR'($urandom);
      ifc.fl_vld     = ($urandom_range(3, 0) != 0);
      ifc.fl         = onehot();
      ifc.fl_ret_rdy = ($urandom_range(2, 0) != 0);
      ifc.flush      = ($urandom_range(49, 0) == 0);
      rand_entries();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
